// File: rtl/adder_seq_ctrl.sv
// Purpose: multi-cycle W-bit add (or subtract with ADD_SEQ_SUB_EN) over a shared external 4-bit adder slice.
// Latency: start at e0, one nibble per edge e1..eN, done/sum_out valid the cycle after eN (N = NIBBLES).
// Backpressure: none; start is honoured only in IDLE and is dropped (not queued) while busy or done.
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic                   cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum_out,
    output logic                   cout_out
);

    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2:0]     idx;
    logic           carry;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   work;
    logic [W-1:0]   work_nxt;
    logic           last;
    logic           init_carry;
    logic           sub_q;

`ifdef ADD_SEQ_SUB_EN
    // Subtraction is A + ~B + 1; cin is deliberately ignored in that mode.
    assign init_carry = sub ? 1'b1 : cin;
`else
    assign init_carry = cin;
`endif

    assign last = (idx == 3'(NIBBLES - 1));

    // Operands are shifted down one nibble per RUN edge so nibble[idx] is always at bits [3:0];
    // results enter at the top, so after N edges work holds the sum in place.
    assign work_nxt = W'({add_sum, work} >> 4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            work     <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            sub_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        idx   <= '0;
                        carry <= init_carry;
`ifdef ADD_SEQ_SUB_EN
                        sub_q <= sub;
`else
                        sub_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> 4;
                    b_reg <= b_reg >> 4;
                    work  <= work_nxt;
                    carry <= add_cout;
                    idx   <= idx + 3'd1;
                    if (last) begin
                        sum_out  <= work_nxt;
                        cout_out <= add_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_reg[3:0];
                add_b   = b_reg[3:0] ^ {4{sub_q}};
                add_cin = carry;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (NIBBLES=4) with a behavioural 4-bit adder slice attached.
module tb_adder_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        cin;
    logic        sub;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;
    logic        busy;
    logic        done;
    logic [15:0] sum_out;
    logic        cout_out;

    int vectors;
    int miscompares;

    adder_seq_ctrl #(.NIBBLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
`ifdef ADD_SEQ_SUB_EN
        .sub      (sub),
`endif
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out)
    );

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts busy cycles until done appears, giving up after a fixed budget.
    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            if (busy) busy_cycles++;
            tick();
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s, input logic [15:0] exp_sum,
                         input logic exp_cout);
        int bc;
        a_in  = a;
        b_in  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        cin   = ~c;
        sub   = ~s;
        chk({tag, "_add_a0"}, 32'(add_a), 32'(a[3:0]));
        chk({tag, "_add_b0"}, 32'(add_b), 32'(s ? ~b[3:0] : b[3:0]));
        chk({tag, "_add_cin0"}, 32'(add_cin), 32'(s ? 1'b1 : c));
        wait_done(bc);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(bc), 32'd4);
        chk({tag, "_sum"}, 32'(sum_out), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(cout_out), 32'(exp_cout));
        chk({tag, "_slice_idle"}, 32'({add_a, add_b, add_cin}), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum_out), 32'(exp_sum));
    endtask

    initial begin
        int dn;
        int bc;
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        start = 1'b0;
        a_in  = 16'hBEEF;
        b_in  = 16'hCAFE;
        cin   = 1'b1;
        sub   = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_cout", 32'(cout_out), 32'd0);
        chk("rst_slice", 32'({add_a, add_b, add_cin}), 32'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        tick();
        chk("rst_prio_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_slice", 32'({add_a, add_b, add_cin}), 32'd0);

        do_op("v1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0);
        do_op("v2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        do_op("v3", 16'h00F0, 16'h0010, 1'b1, 1'b0, 16'h0101, 1'b0);

        // start held with changing operands through RUN and DONE is ignored.
        a_in  = 16'h1234;
        b_in  = 16'h0FFF;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        a_in  = 16'h1111;
        b_in  = 16'h2222;
        cin   = 1'b1;
        dn    = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                dn++;
                start = 1'b0;
            end
            tick();
        end
        chk("ign_done_count", 32'(dn), 32'd1);
        chk("ign_sum", 32'(sum_out), 32'h2233);
        chk("ign_cout", 32'(cout_out), 32'd0);

        // New RUN holds the old result; reset in its second RUN cycle aborts it.
        a_in  = 16'hAAAA;
        b_in  = 16'h1111;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold_during_run", 32'(sum_out), 32'h2233);
        tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum_out), 32'd0);
        chk("abort_cout", 32'(cout_out), 32'd0);
        chk("abort_slice", 32'({add_a, add_b, add_cin}), 32'd0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dn++;
            tick();
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        do_op("v4", 16'h8001, 16'h8002, 1'b1, 1'b0, 16'h0004, 1'b1);

        // start held across DONE launches a new operation from IDLE.
        a_in  = 16'h0001;
        b_in  = 16'h0002;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        wait_done(bc);
        chk("held_first_done", 32'(done), 32'd1);
        tick();
        chk("held_idle_busy", 32'(busy), 32'd0);
        a_in = 16'h0010;
        tick();
        start = 1'b0;
        chk("held_restart_busy", 32'(busy), 32'd1);
        wait_done(bc);
        chk("held_second_done", 32'(done), 32'd1);
        chk("held_second_sum", 32'(sum_out), 32'h0012);
        tick();

`ifdef ADD_SEQ_SUB_EN
        do_op("s1", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        do_op("s2", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, meaning: operand width in 4-bit nibbles (range 1..8); W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a_in  input  W  operand A, captured when start is accepted.
REQ-006 b_in  input  W  operand B, captured when start is accepted.
REQ-007 cin  input  1  initial carry, captured when start is accepted.
REQ-008 add_a  output  4  nibble of A driven to the shared 4-bit adder slice.
REQ-009 add_b  output  4  nibble of B driven to the adder slice.
REQ-010 add_cin  output  1  carry into the adder slice.
REQ-011 add_sum  input  4  combinational sum returned from the adder slice.
REQ-012 add_cout  input  1  combinational carry-out returned from the adder slice.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 sum_out  output  W  registered result, held until the next completion.
REQ-016 cout_out  output  1  registered final carry, held with sum_out.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE; IDLE->RUN on start; RUN->DONE after the nibble with index NIBBLES-1; DONE->IDLE unconditionally.
REQ-018 On start accepted at edge e0, the block SHALL latch a_in, b_in and cin into internal registers, clear the nibble index to 0, and set the carry register to cin.
REQ-019 In RUN, add_a/add_b SHALL equal nibble[idx] of the latched A/B (idx 0 = LSB nibble) and add_cin SHALL equal the carry register.
REQ-020 At each RUN edge, add_sum SHALL be written to working nibble[idx], add_cout to the carry register, and idx incremented.
REQ-021 Carry SHALL propagate nibble to nibble; the final add_cout SHALL become cout_out; no width overflow beyond W+1 bits.
REQ-022 Latency: start at edge e0 -> nibbles captured at edges e1..eN (N = NIBBLES) -> sum_out/cout_out updated and done high for exactly the cycle following edge eN.
REQ-023 sum_out and cout_out SHALL update only on the DONE transition and SHALL otherwise be held, including across a new RUN.
REQ-024 start SHALL be ignored in RUN and DONE; no queuing; a held start in IDLE after DONE SHALL begin a new operation.
REQ-025 In IDLE and DONE, add_a, add_b and add_cin SHALL be driven to 0.
REQ-026 Operand changes on a_in/b_in/cin after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-027 reset SHALL force IDLE, idx=0, carry register=0, busy=0, done=0, sum_out=0, cout_out=0, add_a=add_b=0, add_cin=0.
REQ-028 reset asserted mid-RUN or in DONE SHALL abort the operation without producing done and SHALL clear sum_out/cout_out.
REQ-029 reset SHALL have priority over start in the same cycle.

Configuration
REQ-030 Macro ADD_SEQ_SUB_EN SHALL, when defined, add input port sub (1 bit, captured with the operands); when sub=1, add_b SHALL be the bitwise inverse of the B nibble, the initial carry SHALL be 1 with cin ignored, and cout_out=1 SHALL mean no borrow.
REQ-031 Without ADD_SEQ_SUB_EN, the sub port SHALL NOT exist and the block SHALL only add.

Verification (NIBBLES=4)
REQ-032 Reset, then start with a_in=0x1234, b_in=0x0FFF, cin=0 -> busy high 4 cycles, done pulse 1 cycle, sum_out=0x2233, cout_out=0.
REQ-033 a_in=0xFFFF, b_in=0x0001, cin=0 -> sum_out=0x0000, cout_out=1; a_in=0x00F0, b_in=0x0010, cin=1 -> sum_out=0x0101, cout_out=0.
REQ-034 start re-asserted with new operands during RUN and DONE -> ignored; first result unchanged; exactly one done pulse.
REQ-035 reset asserted at second RUN cycle -> no done pulse, all outputs 0, next start completes correctly in 4 cycles.
REQ-036 With ADD_SEQ_SUB_EN: sub=1, a_in=0x0005, b_in=0x0007 -> sum_out=0xFFFE, cout_out=0; a_in=0x0007, b_in=0x0005 -> sum_out=0x0002, cout_out=1.
